// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy encoding and NOP defaults for elastic pipeline stages
package pipe_pkg;
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE = 2'd1;
   localparam logic [1:0] FULL = 2'd2;
   localparam logic [31:0] RV32_NOP = 32'h0000_0013;
   localparam logic [7:0] CTRL_NOP_DEF = 8'h00;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with priority synchronous clear
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline register with 2-entry skid buffer, flush and stall counter
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEF),
   parameter bit FLUSH_DATA = 1'b1,
   parameter logic [DATA_W-1:0] DATA_NOP = DATA_W'(RV32_NOP),
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   input  logic              clr_cnt_i,
   output logic [CNT_W-1:0]  stall_cnt_o
);
   logic [1:0] state, state_n;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic in_fire, out_fire, load_main, to_skid, pop_skid, drain;
   assign out_valid_o = state != EMPTY;
   assign occupancy_o = state;
   assign in_fire = in_valid_i & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;
   always_comb begin
      load_main = in_fire & (state == EMPTY | (state == ONE & out_fire));
      to_skid = in_fire & state == ONE & ~out_fire;
      pop_skid = out_fire & state == FULL;
      drain = out_fire & ~in_fire & state == ONE;
      state_n = flush_i ? EMPTY : pop_skid ? ONE : to_skid ? FULL : drain ? EMPTY : load_main ? ONE : state;
   end
   // Flush wins over every handshake; a beat accepted in the flush cycle is dropped.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= EMPTY;
         in_ready_o <= 1'b1;
         out_ctrl_o <= CTRL_NOP;
         out_data_o <= DATA_NOP;
         skid_ctrl <= CTRL_NOP;
         skid_data <= DATA_NOP;
      end else begin
         state <= state_n;
         in_ready_o <= state_n != FULL;
         if (flush_i) begin
            out_ctrl_o <= CTRL_NOP;
            skid_ctrl <= CTRL_NOP;
            if (FLUSH_DATA) begin
               out_data_o <= DATA_NOP;
               skid_data <= DATA_NOP;
            end
         end else begin
            if (load_main) begin
               out_ctrl_o <= in_ctrl_i;
               out_data_o <= in_data_i;
            end else if (pop_skid) begin
               out_ctrl_o <= skid_ctrl;
               out_data_o <= skid_data;
            end else if (drain) out_ctrl_o <= CTRL_NOP;
            if (to_skid) begin
               skid_ctrl <= in_ctrl_i;
               skid_data <= in_data_i;
            end else if (pop_skid) skid_ctrl <= CTRL_NOP;
         end
      end
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .inc(out_valid_o & ~out_ready_i),
      .clr(clr_cnt_i),
      .cnt(stall_cnt_o)
   );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_cnt = 1'b0;
   logic [7:0] in_ctrl = '0;
   logic [31:0] in_data = '0;
   logic in_ready, out_valid, nf_in_ready, nf_out_valid, c4_in_ready, c4_out_valid;
   logic [7:0] out_ctrl, nf_ctrl, c4_ctrl;
   logic [31:0] out_data, nf_data, c4_data;
   logic [1:0] occ, nf_occ, c4_occ;
   logic [15:0] cnt, nf_cnt;
   logic [3:0] c4_cnt;
   int errors = 0, checks = 0;
   logic [39:0] q[$];
   logic [31:0] ed, ed_nf;
   int m_cnt, m_c4;
   always #5 clk = ~clk;
   pipe_stage_skid d (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_ctrl_o(out_ctrl), .out_data_o(out_data), .occupancy_o(occ), .clr_cnt_i(clr_cnt),
      .stall_cnt_o(cnt));
   pipe_stage_skid #(.FLUSH_DATA(1'b0)) nf (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(nf_in_ready),
      .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(nf_out_valid), .out_ready_i(out_ready),
      .out_ctrl_o(nf_ctrl), .out_data_o(nf_data), .occupancy_o(nf_occ), .clr_cnt_i(clr_cnt),
      .stall_cnt_o(nf_cnt));
   pipe_stage_skid #(.CNT_W(4)) c4 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(c4_in_ready),
      .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(c4_out_valid), .out_ready_i(out_ready),
      .out_ctrl_o(c4_ctrl), .out_data_o(c4_data), .occupancy_o(c4_occ), .clr_cnt_i(clr_cnt),
      .stall_cnt_o(c4_cnt));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic compare_all();
      logic v;
      logic [39:0] f;
      v = q.size() > 0;
      f = '0;
      if (v) f = q[0];
      check("valid", 32'(out_valid), 32'(v));
      check("ready", 32'(in_ready), 32'(q.size() < 2));
      check("occ", 32'(occ), 32'(q.size()));
      check("ctrl", 32'(out_ctrl), v ? 32'(f[39:32]) : 32'h0);
      check("data", out_data, v ? f[31:0] : ed);
      check("nf_valid", 32'(nf_out_valid), 32'(v));
      check("nf_data", nf_data, v ? f[31:0] : ed_nf);
      check("cnt", 32'(cnt), 32'(m_cnt));
      check("c4_cnt", 32'(c4_cnt), 32'(m_c4));
   endtask
   task automatic model_reset();
      q.delete();
      ed = 32'h13;
      ed_nf = 32'h13;
      m_cnt = 0;
      m_c4 = 0;
   endtask
   task automatic tick(input logic iv, input logic [7:0] c, input logic [31:0] dt,
                       input logic ordy, input logic fl, input logic clr);
      logic ne, infire, ofire;
      in_valid = iv; in_ctrl = c; in_data = dt; out_ready = ordy; flush = fl; clr_cnt = clr;
      ne = q.size() > 0;
      infire = iv && q.size() < 2;
      ofire = ne && ordy;
      if (clr) begin
         m_cnt = 0;
         m_c4 = 0;
      end else if (ne && !ordy) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_c4 < 15) m_c4++;
      end
      if (fl) begin
         if (ne) ed_nf = q[0][31:0];
         ed = 32'h13;
         q.delete();
      end else begin
         if (ofire) begin
            ed = q[0][31:0];
            ed_nf = ed;
            void'(q.pop_front());
         end
         if (infire) q.push_back({c, dt});
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask
   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_ready", 32'(in_ready), 32'h1);
      check("rst_data", out_data, 32'h13);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 8'h01, 32'hA0 + 32'(i), 1'b1, 1'b0, 1'b0);
         check("stream_data", out_data, 32'hA0 + 32'(i));
         check("stream_ready", 32'(in_ready), 32'h1);
      end
      tick(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      tick(1'b1, 8'h02, 32'hB0, 1'b0, 1'b0, 1'b0);
      check("bp_b0", out_data, 32'hB0);
      tick(1'b1, 8'h02, 32'hB1, 1'b0, 1'b0, 1'b0);
      check("bp_occ", 32'(occ), 32'h2);
      check("bp_ready", 32'(in_ready), 32'h0);
      check("bp_cnt1", 32'(cnt), 32'h1);
      tick(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("bp_hold", out_data, 32'hB0);
      check("bp_cnt2", 32'(cnt), 32'h2);
      tick(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("bp_b1", out_data, 32'hB1);
      tick(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("bp_empty", 32'(occ), 32'h0);
      tick(1'b1, 8'h05, 32'hC3, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 8'h05, 32'hC4, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 8'h07, 32'hC5, 1'b0, 1'b1, 1'b0);
      check("fl_occ", 32'(occ), 32'h0);
      check("fl_ctrl", 32'(out_ctrl), 32'h0);
      check("fl_data", out_data, 32'h13);
      check("fl_nf_data", nf_data, 32'hC3);
      repeat (3) tick(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 8'h09, 32'hE0, 1'b0, 1'b0, 1'b1);
      repeat (20) tick(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("sat_c4", 32'(c4_cnt), 32'hF);
      check("cnt20", 32'(cnt), 32'd20);
      tick(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("clr_cnt", 32'(cnt), 32'h0);
      check("clr_c4", 32'(c4_cnt), 32'h0);
      tick(1'b1, 8'h0A, 32'hD1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'h0);
      check("arst_ready", 32'(in_ready), 32'h1);
      check("arst_data", out_data, 32'h13);
      check("arst_occ", 32'(occ), 32'h0);
      check("arst_cnt", 32'(cnt), 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 10000; i++)
         tick($urandom_range(0, 9) < 7, 8'($urandom), $urandom, $urandom_range(0, 9) < 6,
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
